rgb_pwm_driver: RTL
===================

Name: rgb_pwm_driver

Overview:
- Three-channel PWM output stage, directly downstream of the fade/brightness generators.
- Consumes one duty value per colour, each on the same scale as the fade generator's pwm_value (0..PWM_INTERVAL-1), and drives the red, green and blue LED pins.
- Duty updates are double-buffered and committed only at a period boundary, so outputs never glitch mid-period.
- Emits a period_start strobe that upstream stages can use to pace their updates.

Parameters:
- PWM_INTERVAL, 1200, PWM period in clk cycles (100 us at 12 MHz).
- ACTIVE_LOW, 1, when 1 the LED outputs are inverted (pin low = LED on, for current-sink RGB drivers).
- DUTY_W, $clog2(PWM_INTERVAL), width of duty inputs; 11 at default.

Ports:
- clk  in  1  system clock, 12 MHz.
- rst  in  1  asynchronous, active-high reset.
- enable  in  1  run PWM; when low, outputs are held inactive.
- duty_r  in  DUTY_W  red duty, in clk cycles on per period.
- duty_g  in  DUTY_W  green duty.
- duty_b  in  DUTY_W  blue duty.
- duty_load  in  1  single-cycle strobe that captures duty_r/g/b into the pending registers.
- period_start  out  1  one-cycle pulse at the first cycle of each period.
- led_r  out  1  red PWM pin.
- led_g  out  1  green PWM pin.
- led_b  out  1  blue PWM pin.

Behaviour:
- Reset (async, active-high):
  - cnt, pending_x and active_x all clear to 0.
  - period_start is 0.
  - led_x is at the inactive level: 1 if ACTIVE_LOW, else 0.
  - Reset asserted mid-period takes effect immediately; the first period after release starts at cnt=0.
- Counter:
  - cnt runs 0..PWM_INTERVAL-1 and advances by 1 each clk while enable=1.
  - At PWM_INTERVAL-1 it wraps to 0; this is the wrap cycle.
- Capture:
  - On duty_load=1, pending_x <= min(duty_x, PWM_INTERVAL).
  - Values >= PWM_INTERVAL saturate, giving 100% on.
- Commit:
  - In the wrap cycle, active_x <= pending_x.
  - If duty_load coincides with the wrap cycle, the new input value is committed directly, so the next period already uses it.
  - Latency: a load takes effect from the next period start.
- Output:
  - Registered: led_x(t+1) = active level iff enable(t)=1 and cnt(t) < active_x(t).
  - Duty 0 means never on.
  - Duty PWM_INTERVAL means on for every cycle of the period.
  - Duty d gives exactly d on-cycles per period.
- period_start:
  - Registered; high for one cycle, aligned with the led_x cycle that reflects cnt=0.
  - Never asserted while enable=0.
- enable=0:
  - cnt is forced to 0 and active_x <= pending_x every cycle.
  - led_x is inactive and period_start is 0.
  - duty_load still captures.
  - On rising enable, a fresh period starts at cnt=0 with the latest duty; its period_start is seen one cycle later.
- All three channels share cnt and are phase-aligned (left-aligned edges).

Optional Feature:
- Macro: PWM_CENTER_ALIGNED_EN.
- Defined:
  - cnt becomes an up/down counter: up phase 0..PWM_INTERVAL-1, then down phase PWM_INTERVAL-1..0, giving a period of 2*PWM_INTERVAL cycles.
  - Output is on iff cnt < active_x in both phases, so on-time is 2*duty cycles, centred on the period boundary.
  - Commit and period_start occur only at the bottom turnaround: last down-phase cycle with cnt=0, then the up phase begins.
  - All other rules are unchanged, including saturation, enable and reset.
- Undefined: left-aligned sawtooth exactly as specified above.

Test Plan:
- Reset: PWM_INTERVAL=10, ACTIVE_LOW=1. Assert rst asynchronously between clk edges, mid-period with duty 5 -> led_x goes to 1 immediately, period_start=0; after release, first period shows 0 on-cycles until a duty is loaded.
- Basic duty: PWM_INTERVAL=10, ACTIVE_LOW=0, enable=1. Load r=3, g=0, b=10 -> after the next wrap, every period shows led_r high exactly 3 cycles, led_g never high, led_b high all 10; period_start pulses every 10 cycles.
- Glitch-free update: with r=3 running, pulse duty_load with r=7 at cnt=4 -> current period keeps 3 on-cycles; next period has 7. Load r=8 exactly on the wrap cycle -> next period has 8.
- Saturation: load r=15 with PWM_INTERVAL=10 -> led_r on all 10 cycles; no counter corruption.
- Enable: drop enable at cnt=6, load g=2 while disabled, raise enable -> outputs inactive while low; after raise, led_g high for 2 cycles starting with the period_start pulse; cnt restarts at 0.
- Center-aligned (PWM_CENTER_ALIGNED_EN defined, PWM_INTERVAL=10): load r=3 -> period is 20 cycles, led_r high for 6 cycles contiguous across the bottom turnaround; period_start every 20 cycles.

Source files
------------

// File: rtl/rgb_pwm_driver.sv
// rgb_pwm_driver: three-channel PWM output stage for an RGB LED.
// Each channel takes a duty in clk cycles per period. New duties are captured
// into pending registers on duty_load and committed to the active registers
// only at a period boundary, so a period in flight is never disturbed.
// Optional build macro PWM_CENTER_ALIGNED_EN selects an up/down counter,
// which gives 2*PWM_INTERVAL-cycle periods with pulses centred on the boundary.
// Without it, the counter is a left-aligned sawtooth.
module rgb_pwm_driver #(
    parameter int PWM_INTERVAL = 1200,
    parameter bit ACTIVE_LOW   = 1'b1,
    parameter int DUTY_W       = $clog2(PWM_INTERVAL)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic [DUTY_W-1:0] duty_r,
    input  logic [DUTY_W-1:0] duty_g,
    input  logic [DUTY_W-1:0] duty_b,
    input  logic              duty_load,
    output logic              period_start,
    output logic              led_r,
    output logic              led_g,
    output logic              led_b
);

    // Internal width must hold PWM_INTERVAL itself (the 100% duty value).
    localparam int            CW        = $clog2(PWM_INTERVAL + 1);
    localparam logic [CW-1:0] CNT_TOP   = CW'(PWM_INTERVAL - 1);
    localparam logic [CW-1:0] DUTY_FULL = CW'(PWM_INTERVAL);

    logic [2:0][DUTY_W-1:0] duty_raw;
    logic [2:0][CW-1:0]     duty_sat;
    logic [2:0][CW-1:0]     pending;
    logic [2:0][CW-1:0]     active;
    logic [2:0]             led_q;
    logic [CW-1:0]          cnt;
    logic                   wrap;   // last cycle of a period: commit point
    logic                   first;  // first cycle of a period

    assign duty_raw = {duty_b, duty_g, duty_r};

    // Clamp incoming duties so anything at or above the period means always on.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path can infer a latch.
        duty_sat = '0;
        for (int i = 0; i < 3; i++) begin
            if (32'(duty_raw[i]) >= 32'(PWM_INTERVAL))
                duty_sat[i] = DUTY_FULL;
            else
                duty_sat[i] = CW'(duty_raw[i]);
        end
    end

`ifdef PWM_CENTER_ALIGNED_EN
    logic down;  // 1 during the down-counting half of the period

    // The period boundary is the bottom turnaround: down phase ends at 0, up phase begins at 0.
    assign wrap  = down && (cnt == '0);
    assign first = !down && (cnt == '0);

    // Up/down counter; each end value is held for two cycles (one per phase).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt  <= '0;
            down <= 1'b0;
        end else if (!enable) begin
            cnt  <= '0;
            down <= 1'b0;
        end else if (!down) begin
            if (cnt == CNT_TOP)
                down <= 1'b1;
            else
                cnt <= cnt + CW'(1);
        end else begin
            if (cnt == '0)
                down <= 1'b0;
            else
                cnt <= cnt - CW'(1);
        end
    end
`else
    assign wrap  = (cnt == CNT_TOP);
    assign first = (cnt == '0);

    // Sawtooth counter 0..PWM_INTERVAL-1, parked at 0 while disabled.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: state registers use non-blocking assignment so all flops see pre-edge values.
        if (rst)
            cnt <= '0;
        else if (!enable || wrap)
            cnt <= '0;
        else
            cnt <= cnt + CW'(1);
    end
`endif

    // Capture on duty_load; commit pending to active at the boundary or continuously while idle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending <= '0;
            active  <= '0;
        end else begin
            if (duty_load)
                pending <= duty_sat;
            // A load landing on the commit cycle bypasses pending so the next period uses it.
            if (!enable || wrap)
                active <= duty_load ? duty_sat : pending;
        end
    end

    // Registered pin drive and period strobe, both reflecting the counter value of the previous cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            led_q        <= {3{ACTIVE_LOW}};
            period_start <= 1'b0;
        end else begin
            for (int i = 0; i < 3; i++)
                led_q[i] <= (enable && (cnt < active[i])) ^ ACTIVE_LOW;
            period_start <= enable && first;
        end
    end

    assign led_r = led_q[0];
    assign led_g = led_q[1];
    assign led_b = led_q[2];

endmodule
